// File: rtl/iter_mul_unit_if.sv
// Request/response bundle for the iterative multiply/MAC unit.
// The master (core controller) issues start with operands; the slave
// (execute unit) answers with busy/done, the product halves and flags.
interface iter_mul_unit_if #(
  parameter int WIDTH = 32
);

  // Request side
  logic             start;
  logic [1:0]       op;
  logic             s_flag;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic [3:0]       nzcv_in;

  // Response side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       nzcv_out;
  logic             flags_we;

  modport master (
    output start, op, s_flag, a, b, acc, nzcv_in,
    input  busy, done, result_lo, result_hi, nzcv_out, flags_we
  );

  modport slave (
    input  start, op, s_flag, a, b, acc, nzcv_in,
    output busy, done, result_lo, result_hi, nzcv_out, flags_we
  );

endinterface

// File: rtl/iter_mul_unit.sv
// Multi-cycle multiply / multiply-accumulate execute unit (MUL, MLA,
// UMULL, SMULL) built on a radix-2 shift-add engine. One partial-product
// bit is retired per RUN cycle; a single FIN cycle applies the SMULL sign
// fix-up or the MLA accumulate and registers the results and flags.
module iter_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  iter_mul_unit_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_UMULL = 2'b10;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  // Control state and registered outputs
  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;
  logic             flags_we_q;
  logic [WIDTH-1:0] result_lo_q;
  logic [WIDTH-1:0] result_hi_q;
  logic [3:0]       nzcv_q;

  // Operands latched at acceptance and the running product
  logic [1:0]         op_q;
  logic               s_flag_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mult_q;
  logic [WIDTH-1:0]   acc_in_q;
  logic [1:0]         cv_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] prod_q;

  // Combinational next values
  logic               accept;
  logic               is_smull_req;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [WIDTH-1:0]   addend_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic               is_long_q;
  logic [2*WIDTH-1:0] prod_fix_d;
  logic [WIDTH-1:0]   result_lo_d;
  logic [WIDTH-1:0]   result_hi_d;
  logic [3:0]         nzcv_d;

  // Magnitude of a two's-complement operand; the most-negative value maps
  // to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign accept       = (state_q == S_IDLE) && bus.start;
  assign is_smull_req = (bus.op == OP_SMULL);

  // Signed long multiply runs the unsigned engine on magnitudes
  always_comb begin
    a_mag_d = bus.a;
    b_mag_d = bus.b;
    if (is_smull_req) begin
      a_mag_d = magnitude(bus.a);
      b_mag_d = magnitude(bus.b);
    end
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift {carry, product} right by one.
  always_comb begin
    addend_d = mult_q[0] ? mcand_q : '0;
    sum_d    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_d};
    prod_d   = {sum_d, prod_q[WIDTH-1:1]};
  end

  // Final product shaping: sign fix-up, accumulate, truncation and flags
  always_comb begin
    is_long_q  = op_q[1];
    prod_fix_d = prod_q;
    if ((op_q == OP_SMULL) && sign_q) begin
      prod_fix_d = ~prod_q + (2*WIDTH)'(1);
    end

    result_lo_d = prod_fix_d[WIDTH-1:0];
    result_hi_d = '0;
    unique case (op_q)
      OP_MUL:   result_lo_d = prod_q[WIDTH-1:0];
      OP_MLA:   result_lo_d = prod_q[WIDTH-1:0] + acc_in_q;
      OP_UMULL,
      OP_SMULL: begin
        result_lo_d = prod_fix_d[WIDTH-1:0];
        result_hi_d = prod_fix_d[2*WIDTH-1:WIDTH];
      end
      default:  result_lo_d = prod_q[WIDTH-1:0];
    endcase

    if (is_long_q) begin
      nzcv_d = {result_hi_d[WIDTH-1], ({result_hi_d, result_lo_d} == '0), cv_q};
    end else begin
      nzcv_d = {result_lo_d[WIDTH-1], (result_lo_d == '0), cv_q};
    end
  end

  // Operand capture and shift-add iteration; data needs no reset because
  // the controller never consumes it outside an accepted operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= bus.op;
      s_flag_q <= bus.s_flag;
      mcand_q  <= a_mag_d;
      mult_q   <= b_mag_d;
      acc_in_q <= bus.acc;
      cv_q     <= bus.nzcv_in[1:0];
      sign_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      prod_q   <= '0;
    end else if (state_q == S_RUN) begin
      prod_q <= prod_d;
      mult_q <= mult_q >> 1;
    end
  end

  // Sequencer IDLE -> RUN (WIDTH cycles) -> FIN -> IDLE with registered handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flags_we_q  <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      nzcv_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q     <= 1'b0;
          flags_we_q <= 1'b0;
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        S_RUN: begin
          count_q <= count_q + CW'(1);
          if (count_q == LAST_CNT) begin
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          flags_we_q  <= s_flag_q;
          result_lo_q <= result_lo_d;
          result_hi_q <= result_hi_d;
          nzcv_q      <= nzcv_d;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.flags_we  = flags_we_q;
  assign bus.result_lo = result_lo_q;
  assign bus.result_hi = result_hi_q;
  assign bus.nzcv_out  = nzcv_q;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Scoreboard bench for iter_mul_unit: the driver pushes hand-computed
// expectations when it issues an op; the monitor pops them on done.
module tb_iter_mul_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   nzcv;
    logic         fwe;
    int           cyc;
    string        nm;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  iter_mul_unit_if #(.WIDTH(W)) bus ();

  iter_mul_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_lo"},   64'(bus.result_lo), 64'(e.lo));
        check({e.nm, "_hi"},   64'(bus.result_hi), 64'(e.hi));
        check({e.nm, "_nzcv"}, 64'(bus.nzcv_out),  64'(e.nzcv));
        check({e.nm, "_fwe"},  64'(bus.flags_we),  64'(e.fwe));
        check({e.nm, "_busy"}, 64'(bus.busy),      64'(0));
        check({e.nm, "_lat"},  64'(cyc),           64'(e.cyc));
      end
    end
  end

  // Drive one request for a single cycle (called at a negedge)
  task automatic issue(input logic [1:0] op, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] acc, input logic [3:0] nz,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic [3:0] enz,
                       input string nm, input bit push);
    exp_t e;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.s_flag  = s;
    bus.a       = a;
    bus.b       = b;
    bus.acc     = acc;
    bus.nzcv_in = nz;
    if (push) begin
      e.lo = elo; e.hi = ehi; e.nzcv = enz; e.fwe = s; e.cyc = cyc + LAT; e.nm = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait, bounded, until done is visible at a negedge
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, n);
    end
  endtask

  initial begin
    int ndone;
    int n;
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.s_flag = 1'b0;
    bus.a = '0; bus.b = '0; bus.acc = '0; bus.nzcv_in = 4'b0000;
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(bus.busy),      64'(0));
    check("rst_done", 64'(bus.done),      64'(0));
    check("rst_fwe",  64'(bus.flags_we),  64'(0));
    check("rst_lo",   64'(bus.result_lo), 64'(0));
    check("rst_hi",   64'(bus.result_hi), 64'(0));
    check("rst_nzcv", 64'(bus.nzcv_out),  64'(0));
    rst = 1'b0;
    @(negedge clk);

    // MUL 7*6, flags updated, C/V preserved from nzcv_in=0110
    issue(2'b00, 1'b1, 32'd7, 32'd6, 32'd0, 4'b0110, 32'd42, 32'd0, 4'b0010, "mul7x6", 1'b1);
    check("busy_after_accept", 64'(bus.busy), 64'(1));
    wait_done("mul7x6");
    @(negedge clk);

    // MLA wraps: 0xFFFFFFFF*2 + 3 = 1 (mod 2^32), no flag write
    issue(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd3, 4'b1001, 32'h0000_0001, 32'd0, 4'b0001, "mla", 1'b1);
    wait_done("mla");
    @(negedge clk);

    // UMULL of all-ones
    issue(2'b10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b0000,
          32'h0000_0001, 32'hFFFF_FFFE, 4'b1000, "umull", 1'b1);
    wait_done("umull");
    @(negedge clk);

    // SMULL most-negative * -1 = +2^31
    issue(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'b1111,
          32'h8000_0000, 32'h0000_0000, 4'b0011, "smull_min", 1'b1);
    wait_done("smull_min");
    @(negedge clk);

    // SMULL -3*5 = -15
    issue(2'b11, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'd0, 4'b0000,
          32'hFFFF_FFF1, 32'hFFFF_FFFF, 4'b1000, "smull_neg", 1'b1);
    wait_done("smull_neg");
    @(negedge clk);

    // start held high (with changing operands) while busy: exactly one op
    issue(2'b00, 1'b0, 32'd3, 32'd5, 32'd0, 4'b0000, 32'd15, 32'd0, 4'b0000, "held", 1'b1);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    repeat (25) @(negedge clk);
    bus.start = 1'b0;
    wait_done("held");
    @(negedge clk);

    // Back-to-back: UMULL 2^16*2^16, then MUL issued in its done cycle
    issue(2'b10, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0000,
          32'h0000_0000, 32'h0000_0001, 4'b0000, "b2b_umull", 1'b1);
    wait_done("b2b_umull");
    issue(2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0000,
          32'h0000_0000, 32'h0000_0000, 4'b0100, "b2b_mul", 1'b1);
    wait_done("b2b_mul");
    @(negedge clk);

    // Reset during RUN at count=10: abort, outputs cleared, no done
    issue(2'b10, 1'b1, 32'd1234, 32'd5678, 32'd0, 4'b0000, 32'd0, 32'd0, 4'b0000, "abort", 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy),      64'(0));
    check("abort_done", 64'(bus.done),      64'(0));
    check("abort_lo",   64'(bus.result_lo), 64'(0));
    check("abort_hi",   64'(bus.result_hi), 64'(0));
    check("abort_nzcv", 64'(bus.nzcv_out),  64'(0));
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'(0));

    // Zero operand after abort: Z set, C/V preserved
    issue(2'b00, 1'b1, 32'd0, 32'd9, 32'd0, 4'b0011, 32'd0, 32'd0, 4'b0111, "mul_zero", 1'b1);
    wait_done("mul_zero");
    @(negedge clk);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
